// File: rtl/mod_inv_if.sv
// Handshake bundle for the GF(65537) inverter: operand in, inverse out.
interface mod_inv_if #(
  parameter int unsigned BITLEN = 17
);
  logic              in_valid;
  logic              in_ready;
  logic [BITLEN-1:0] in_a;
  logic              out_valid;
  logic              out_ready;
  logic [BITLEN-1:0] out_inv;

  modport master (
    output in_valid, in_a, out_ready,
    input  in_ready, out_valid, out_inv
  );

  modport slave (
    input  in_valid, in_a, out_ready,
    output in_ready, out_valid, out_inv
  );
endinterface

// File: rtl/mod_inv.sv
// Sequential inverter over GF(65537): a^(Q-2) by a fixed square-and-multiply chain
// on one 3-phase (multiply, fold, correct) modular multiplier.
module mod_inv #(
  parameter int unsigned BITLEN = 17,
  parameter int unsigned Q      = 65537
) (
  input logic       clk,
  input logic       rst,
  mod_inv_if.slave  bus
);

  localparam int unsigned PW = 2 * BITLEN;

  localparam logic [BITLEN-1:0] QB       = BITLEN'(Q);
  localparam logic [BITLEN+1:0] QW       = (BITLEN+2)'(Q);
  localparam logic [3:0]        LastIter = 4'd14;

  typedef enum logic [1:0] {StIdle, StSq, StMl, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [BITLEN-1:0] r_q, r_d;
  logic [BITLEN-1:0] a_q, a_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [BITLEN:0]   red_q, red_d;
  logic [BITLEN-1:0] inv_q, inv_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [BITLEN-1:0] a_in_red;
  logic [BITLEN-1:0] mul_y;
  logic [BITLEN+1:0] fold;
  logic [BITLEN+1:0] t_ext, t_sub, t_add;
  logic [BITLEN-1:0] corr;

  assign a_in_red = (bus.in_a >= QB) ? (bus.in_a - QB) : bus.in_a;
  assign mul_y    = (state_q == StSq) ? r_q : a_q;

  // 2^17 == -2 mod Q, so P = hi*2^17 + lo folds to lo - 2*hi.
  assign fold = {2'b00, prod_q[BITLEN-1:0]} - {1'b0, prod_q[PW-1:BITLEN], 1'b0};

  assign t_ext = {red_q[BITLEN], red_q};
  assign t_sub = t_ext - QW;
  assign t_add = t_ext + QW;

  always_comb begin
    corr = BITLEN'(t_add);
    if (!t_sub[BITLEN+1]) begin
      corr = BITLEN'(t_sub);
    end else if (!t_ext[BITLEN+1]) begin
      corr = BITLEN'(t_ext);
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    a_d     = a_q;
    prod_d  = prod_q;
    red_d   = red_q;
    inv_d   = inv_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && in_ready_q) begin
          a_d     = a_in_red;
          r_d     = a_in_red;
          cnt_d   = 4'd0;
          phase_d = 2'd0;
          state_d = StSq;
        end
      end
      StSq, StMl: begin
        unique case (phase_q)
          2'd0: begin
            prod_d  = PW'(r_q) * PW'(mul_y);
            phase_d = 2'd1;
          end
          2'd1: begin
            red_d   = (BITLEN+1)'(fold);
            phase_d = 2'd2;
          end
          default: begin
            r_d     = corr;
            phase_d = 2'd0;
            if (state_q == StSq) begin
              state_d = StMl;
            end else begin
              cnt_d = cnt_q + 4'd1;
              if (cnt_q == LastIter) begin
                inv_d   = corr;
                state_d = StDone;
              end else begin
                state_d = StSq;
              end
            end
          end
        endcase
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
    endcase

    in_ready_d  = (state_d == StIdle);
    out_valid_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      phase_q     <= 2'd0;
      cnt_q       <= 4'd0;
      r_q         <= '0;
      a_q         <= '0;
      prod_q      <= '0;
      red_q       <= '0;
      inv_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      a_q         <= a_d;
      prod_q      <= prod_d;
      red_q       <= red_d;
      inv_q       <= inv_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_inv   = inv_q;

endmodule

// File: tb/tb_mod_inv.sv
// Directed vector table plus reset/backpressure/busy-input sequences and a modelled random run.
module tb_mod_inv;

  localparam int unsigned QM = 65537;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mod_inv_if #(.BITLEN(17)) bus ();

  mod_inv #(.BITLEN(17), .Q(65537)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] a;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Right-to-left binary exponentiation, independent of the DUT's chain.
  function automatic logic [16:0] pow_model(input logic [16:0] a);
    longint unsigned b, r, e;
    b = longint'(a) % QM;
    r = 1;
    e = QM - 2;
    while (e != 0) begin
      if (e[0]) r = (r * b) % QM;
      b = (b * b) % QM;
      e = e >> 1;
    end
    return 17'(r);
  endfunction

  task automatic run_op(input logic [16:0] a, input int stall, input bit garbage,
                        output logic [16:0] res, output int lat);
    int          n;
    bit          stable;
    bit          busy_ok;
    logic [16:0] held;
    n = 0;
    while (!bus.in_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    bus.in_a      = a;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) busy_ok = 1'b0;
      if (garbage) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_a     = 17'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    res    = bus.out_inv;
    held   = res;
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (bus.out_inv !== held || !bus.out_valid || bus.in_ready) stable = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("busy_in_ready_low", 32'(busy_ok), 32'd1);
    chk("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
    if (stall > 0) chk("stall_hold_stable", 32'(stable), 32'd1);
  endtask

  initial begin
    logic [16:0] res;
    logic [16:0] ar;
    int          lat;
    bit          stale;
    bit          extra;

    checks   = 0;
    failures = 0;

    vecs[0]  = '{a: 17'd2,      exp: 17'd32769};
    vecs[1]  = '{a: 17'd3,      exp: 17'd21846};
    vecs[2]  = '{a: 17'd1,      exp: 17'd1};
    vecs[3]  = '{a: 17'd65536,  exp: 17'd65536};
    vecs[4]  = '{a: 17'd0,      exp: 17'd0};
    vecs[5]  = '{a: 17'd65537,  exp: 17'd0};
    vecs[6]  = '{a: 17'd131071, exp: 17'd43691};
    vecs[7]  = '{a: 17'd65535,  exp: 17'd32768};
    vecs[8]  = '{a: 17'd4,      exp: 17'd49153};
    vecs[9]  = '{a: 17'd131070, exp: 17'd16384};
    vecs[10] = '{a: 17'd256,    exp: 17'd65281};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_inv", 32'(bus.out_inv), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("after_reset_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, 0, 1'b0, res, lat);
      chk($sformatf("vec%0d_inv", i), 32'(res), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd90);
    end

    // Reset 40 cycles into a chain: everything clears and nothing resumes.
    bus.in_a     = 17'd5;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_inv", 32'(bus.out_inv), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_in_ready_after", 32'(bus.in_ready), 32'd1);
    stale = 1'b0;
    repeat (120) begin
      @(posedge clk); #1;
      if (bus.out_valid) stale = 1'b1;
    end
    chk("midrst_no_stale", 32'(stale), 32'd0);

    run_op(17'd7, 20, 1'b0, res, lat);
    chk("bp_inv", 32'(res), 32'(pow_model(17'd7)));

    run_op(17'd12345, 3, 1'b1, res, lat);
    chk("garbage_inv", 32'(res), 32'(pow_model(17'd12345)));
    chk("garbage_latency", 32'(lat), 32'd90);
    extra = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.out_valid || !bus.in_ready) extra = 1'b1;
    end
    chk("garbage_no_extra_txn", 32'(extra), 32'd0);

    for (int i = 0; i < 300; i++) begin
      logic [16:0] a;
      a  = 17'($urandom_range(0, 131071));
      ar = (a >= 17'd65537) ? a - 17'd65537 : a;
      run_op(a, int'($urandom_range(0, 3)), 1'b0, res, lat);
      chk("rand_inv", 32'(res), 32'(pow_model(a)));
      if (res != 0) chk("rand_product_one", 32'((longint'(res) * longint'(ar)) % QM), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
